// File: rtl/gray_pos_tracker_if.sv
// Bundle between the Gray lookup stage, the position tracker and its readout.
// The upstream stage drives the code and clear; the tracker drives position and status.
interface gray_pos_tracker_if #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 16
);
  logic        [WIDTH-1:0]     gray_in;
  logic                        in_valid;
  logic                        clr;
  logic signed [CNT_WIDTH-1:0] pos;
  logic        [WIDTH-1:0]     idx;
  logic                        step_valid;
  logic                        step_dir;
  logic                        err;
  logic                        locked;

  modport master (
    output gray_in, in_valid, clr,
    input  pos, idx, step_valid, step_dir, err, locked
  );

  modport slave (
    input  gray_in, in_valid, clr,
    output pos, idx, step_valid, step_dir, err, locked
  );
endinterface

// File: rtl/gray_pos_tracker.sv
// Debounces a Gray-coded position index, classifies each accepted change as a
// forward step, backward step or illegal jump, and keeps a signed position count.
module gray_pos_tracker #(
  parameter int WIDTH         = 2,
  parameter int CNT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  gray_pos_tracker_if.slave bus
);

  localparam int               CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]    STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0] FWD      = WIDTH'(1);
  localparam logic [WIDTH-1:0] BWD      = {WIDTH{1'b1}};

  typedef enum logic {S_INIT, S_TRACK} state_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  state_t                      state_q, state_d;
  logic        [WIDTH-1:0]     cand_q, cand_d;
  logic        [CW-1:0]        cnt_q, cnt_d;
  logic        [WIDTH-1:0]     idx_q, idx_d;
  logic signed [CNT_WIDTH-1:0] pos_q, pos_d;
  logic                        sv_q, sv_d;
  logic                        dir_q, dir_d;
  logic                        err_q, err_d;
  logic                        locked_q, locked_d;
  logic                        accept;
  logic        [WIDTH-1:0]     bin;
  logic        [WIDTH-1:0]     delta;

  // Debounce: the count saturates at STABLE_CYCLES so a stable run is accepted once.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (bus.in_valid) begin
      if (bus.gray_in != cand_q) begin
        cand_d = bus.gray_in;
        cnt_d  = CW'(1);
        accept = (STABLE_CYCLES == 1);
      end else if (cnt_q < STABLE_C) begin
        cnt_d  = cnt_q + CW'(1);
        accept = ((cnt_q + CW'(1)) == STABLE_C);
      end
    end
  end

  assign bin   = gray2bin(bus.gray_in);
  assign delta = bin - idx_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    sv_d     = 1'b0;
    dir_d    = dir_q;
    err_d    = err_q;
    locked_d = locked_q;
    case (state_q)
      S_INIT: begin
        if (accept) begin
          idx_d    = bin;
          locked_d = 1'b1;
          state_d  = S_TRACK;
        end
      end
      S_TRACK: begin
        if (accept && (delta != '0)) begin
          idx_d = bin;
          if (delta == FWD) begin
            pos_d = pos_q + CNT_WIDTH'(1);
            dir_d = 1'b1;
            sv_d  = 1'b1;
          end else if (delta == BWD) begin
            pos_d = pos_q - CNT_WIDTH'(1);
            dir_d = 1'b0;
            sv_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
    // Clear overrides only the count and error; the step pulse and index still update.
    if (bus.clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      cand_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      pos_q    <= '0;
      sv_q     <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      sv_q     <= sv_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign bus.pos        = pos_q;
  assign bus.idx        = idx_q;
  assign bus.step_valid = sv_q;
  assign bus.step_dir   = dir_q;
  assign bus.err        = err_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Bench for gray_pos_tracker: a 16-bit and a 4-bit counter instance share one
// stimulus stream; expected step events are queued and matched against step_valid.
module tb_gray_pos_tracker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  logic prev_sv = 1'b0;

  typedef struct packed {
    logic        dir;
    logic [15:0] pos;
    logic [1:0]  idx;
  } step_t;

  step_t exp_q[$];

  gray_pos_tracker_if #(.WIDTH(2), .CNT_WIDTH(16)) b16 ();
  gray_pos_tracker_if #(.WIDTH(2), .CNT_WIDTH(4))  b4 ();

  assign b4.gray_in  = b16.gray_in;
  assign b4.in_valid = b16.in_valid;
  assign b4.clr      = b16.clr;

  gray_pos_tracker #(.WIDTH(2), .CNT_WIDTH(16), .STABLE_CYCLES(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  gray_pos_tracker #(.WIDTH(2), .CNT_WIDTH(4), .STABLE_CYCLES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  always #5 clk = ~clk;

  // Every step_valid pulse must match the oldest queued expectation and last one cycle.
  always @(posedge clk) begin
    #1;
    if (b16.step_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL step_unexpected got dir=%0b pos=%0d idx=%0d want no step",
                 b16.step_dir, b16.pos, b16.idx);
      end else begin
        step_t e;
        e = exp_q.pop_front();
        if ({b16.step_dir, b16.pos, b16.idx} !== e)
          $display("FAIL step_event got dir=%0b pos=%h idx=%0d want dir=%0b pos=%h idx=%0d",
                   b16.step_dir, b16.pos, b16.idx, e.dir, e.pos, e.idx);
        else n_pass++;
      end
      n_total++;
      if (prev_sv === 1'b1) $display("FAIL step_pulse_width got 2+ cycles want 1");
      else n_pass++;
    end
    prev_sv = b16.step_valid;
  end

  task automatic hold(input logic [1:0] g, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b16.gray_in  = g;
      b16.in_valid = v;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] g, input logic dir, input logic [15:0] p,
                      input logic [1:0] ix);
    exp_q.push_back({dir, p, ix});
    hold(g, 1'b1, 4);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++; if (b16.pos !== 16'd0) $display("FAIL reset_pos got %h want 0", b16.pos); else n_pass++;
    n_total++; if (b16.idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", b16.idx); else n_pass++;
    n_total++; if (b16.step_valid !== 1'b0) $display("FAIL reset_sv got %b want 0", b16.step_valid); else n_pass++;
    n_total++; if (b16.step_dir !== 1'b0) $display("FAIL reset_dir got %b want 0", b16.step_dir); else n_pass++;
    n_total++; if (b16.err !== 1'b0) $display("FAIL reset_err got %b want 0", b16.err); else n_pass++;
    n_total++; if (b16.locked !== 1'b0) $display("FAIL reset_locked got %b want 0", b16.locked); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    hold(2'b00, 1'b1, 3);
    n_total++; if (b16.locked !== 1'b0) $display("FAIL lock_early got %b want 0", b16.locked); else n_pass++;
    hold(2'b00, 1'b1, 1);
    n_total++; if (b16.locked !== 1'b1) $display("FAIL lock_locked got %b want 1", b16.locked); else n_pass++;
    n_total++; if (b16.idx !== 2'd0) $display("FAIL lock_idx got %0d want 0", b16.idx); else n_pass++;
    n_total++; if (b16.pos !== 16'd0) $display("FAIL lock_pos got %h want 0", b16.pos); else n_pass++;
    n_total++; if (b16.step_valid !== 1'b0) $display("FAIL lock_sv got %b want 0", b16.step_valid); else n_pass++;
  endtask

  task automatic test_forward;
    step(2'b01, 1'b1, 16'd1, 2'd1);
    step(2'b11, 1'b1, 16'd2, 2'd2);
    step(2'b10, 1'b1, 16'd3, 2'd3);
    n_total++; if (b16.pos !== 16'd3) $display("FAIL fwd_pos got %h want 3", b16.pos); else n_pass++;
    n_total++; if (b16.idx !== 2'd3) $display("FAIL fwd_idx got %0d want 3", b16.idx); else n_pass++;
    n_total++; if (b16.step_dir !== 1'b1) $display("FAIL fwd_dir got %b want 1", b16.step_dir); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL fwd_missing got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backward;
    step(2'b11, 1'b0, 16'd2, 2'd2);
    step(2'b01, 1'b0, 16'd1, 2'd1);
    step(2'b00, 1'b0, 16'd0, 2'd0);
    step(2'b10, 1'b0, 16'hFFFF, 2'd3);
    n_total++; if (b16.pos !== 16'hFFFF) $display("FAIL bwd_pos got %h want ffff", b16.pos); else n_pass++;
    n_total++; if (b4.pos !== 4'hF) $display("FAIL bwd_pos4 got %h want f", b4.pos); else n_pass++;
    n_total++; if (b16.idx !== 2'd3) $display("FAIL bwd_idx got %0d want 3", b16.idx); else n_pass++;
    n_total++; if (b16.step_dir !== 1'b0) $display("FAIL bwd_dir got %b want 0", b16.step_dir); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL bwd_missing got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_debounce;
    step(2'b00, 1'b1, 16'd0, 2'd0);
    hold(2'b01, 1'b1, 2);
    hold(2'b00, 1'b1, 4);
    n_total++; if (b16.pos !== 16'd0) $display("FAIL glitch_pos got %h want 0", b16.pos); else n_pass++;
    n_total++; if (b16.idx !== 2'd0) $display("FAIL glitch_idx got %0d want 0", b16.idx); else n_pass++;
    hold(2'b01, 1'b1, 2);
    hold(2'b11, 1'b0, 3);
    hold(2'b01, 1'b1, 1);
    n_total++; if (b16.pos !== 16'd0) $display("FAIL gap_early_pos got %h want 0", b16.pos); else n_pass++;
    exp_q.push_back({1'b1, 16'd1, 2'd1});
    hold(2'b01, 1'b1, 1);
    n_total++; if (b16.pos !== 16'd1) $display("FAIL gap_pos got %h want 1", b16.pos); else n_pass++;
    n_total++; if (b16.step_valid !== 1'b1) $display("FAIL gap_sv got %b want 1", b16.step_valid); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL deb_missing got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_illegal;
    step(2'b11, 1'b1, 16'd2, 2'd2);
    step(2'b10, 1'b1, 16'd3, 2'd3);
    step(2'b00, 1'b1, 16'd4, 2'd0);
    hold(2'b11, 1'b1, 4);
    n_total++; if (b16.err !== 1'b1) $display("FAIL ill_err got %b want 1", b16.err); else n_pass++;
    n_total++; if (b16.idx !== 2'd2) $display("FAIL ill_idx got %0d want 2", b16.idx); else n_pass++;
    n_total++; if (b16.pos !== 16'd4) $display("FAIL ill_pos got %h want 4", b16.pos); else n_pass++;
    n_total++; if (b16.step_valid !== 1'b0) $display("FAIL ill_sv got %b want 0", b16.step_valid); else n_pass++;
    hold(2'b11, 1'b1, 3);
    n_total++; if (b16.err !== 1'b1) $display("FAIL ill_sticky got %b want 1", b16.err); else n_pass++;
    @(negedge clk);
    b16.clr = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (b16.err !== 1'b0) $display("FAIL clr_err got %b want 0", b16.err); else n_pass++;
    n_total++; if (b16.pos !== 16'd0) $display("FAIL clr_pos got %h want 0", b16.pos); else n_pass++;
    n_total++; if (b16.idx !== 2'd2) $display("FAIL clr_idx got %0d want 2", b16.idx); else n_pass++;
    n_total++; if (b16.locked !== 1'b1) $display("FAIL clr_locked got %b want 1", b16.locked); else n_pass++;
    @(negedge clk);
    b16.clr = 1'b0;
  endtask

  task automatic test_wrap;
    step(2'b10, 1'b1, 16'd1, 2'd3);
    step(2'b00, 1'b1, 16'd2, 2'd0);
    step(2'b01, 1'b1, 16'd3, 2'd1);
    step(2'b11, 1'b1, 16'd4, 2'd2);
    step(2'b10, 1'b1, 16'd5, 2'd3);
    step(2'b00, 1'b1, 16'd6, 2'd0);
    step(2'b01, 1'b1, 16'd7, 2'd1);
    n_total++; if (b4.pos !== 4'd7) $display("FAIL wrap_pre got %h want 7", b4.pos); else n_pass++;
    step(2'b11, 1'b1, 16'd8, 2'd2);
    n_total++; if (b4.pos !== 4'b1000) $display("FAIL wrap_pos4 got %b want 1000", b4.pos); else n_pass++;
    n_total++; if (b16.pos !== 16'd8) $display("FAIL wrap_pos16 got %h want 8", b16.pos); else n_pass++;
    hold(2'b10, 1'b1, 3);
    exp_q.push_back({1'b1, 16'd0, 2'd3});
    @(negedge clk);
    b16.gray_in  = 2'b10;
    b16.in_valid = 1'b1;
    b16.clr      = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (b16.pos !== 16'd0) $display("FAIL clrstep_pos got %h want 0", b16.pos); else n_pass++;
    n_total++; if (b4.pos !== 4'd0) $display("FAIL clrstep_pos4 got %h want 0", b4.pos); else n_pass++;
    n_total++; if (b16.step_valid !== 1'b1) $display("FAIL clrstep_sv got %b want 1", b16.step_valid); else n_pass++;
    n_total++; if (b16.idx !== 2'd3) $display("FAIL clrstep_idx got %0d want 3", b16.idx); else n_pass++;
    @(negedge clk);
    b16.clr = 1'b0;
  endtask

  task automatic test_reset_mid;
    step(2'b00, 1'b1, 16'd1, 2'd0);
    step(2'b01, 1'b1, 16'd2, 2'd1);
    step(2'b11, 1'b1, 16'd3, 2'd2);
    step(2'b10, 1'b1, 16'd4, 2'd3);
    step(2'b00, 1'b1, 16'd5, 2'd0);
    hold(2'b01, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (b16.pos !== 16'd0) $display("FAIL arst_pos got %h want 0", b16.pos); else n_pass++;
    n_total++; if (b16.idx !== 2'd0) $display("FAIL arst_idx got %0d want 0", b16.idx); else n_pass++;
    n_total++; if (b16.step_dir !== 1'b0) $display("FAIL arst_dir got %b want 0", b16.step_dir); else n_pass++;
    n_total++; if (b16.locked !== 1'b0) $display("FAIL arst_locked got %b want 0", b16.locked); else n_pass++;
    n_total++; if (b16.err !== 1'b0) $display("FAIL arst_err got %b want 0", b16.err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    hold(2'b10, 1'b1, 3);
    n_total++; if (b16.locked !== 1'b0) $display("FAIL relock_early got %b want 0", b16.locked); else n_pass++;
    hold(2'b10, 1'b1, 1);
    n_total++; if (b16.locked !== 1'b1) $display("FAIL relock_locked got %b want 1", b16.locked); else n_pass++;
    n_total++; if (b16.idx !== 2'd3) $display("FAIL relock_idx got %0d want 3", b16.idx); else n_pass++;
    n_total++; if (b16.pos !== 16'd0) $display("FAIL relock_pos got %h want 0", b16.pos); else n_pass++;
    n_total++; if (b16.step_valid !== 1'b0) $display("FAIL relock_sv got %b want 0", b16.step_valid); else n_pass++;
  endtask

  initial begin
    b16.gray_in  = 2'b00;
    b16.in_valid = 1'b0;
    b16.clr      = 1'b0;
    test_reset;
    test_lock;
    test_forward;
    test_backward;
    test_debounce;
    test_illegal;
    test_wrap;
    test_reset_mid;
    repeat (2) @(negedge clk);
    n_total++; if (exp_q.size() != 0) $display("FAIL final_missing got %0d pending want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
